// File: rtl/fa_norm_pack.sv
// fa_norm_pack: back end of the FP adder. Adds the aligned significands, then
// normalizes one bit per cycle and packs an IEEE-754 single-precision word.
// Truncating; no special-value handling on the inputs.
//
// Ports:
//   CLK, RESETn          clock (rising edge), async active-low reset
//   in_valid / in_ready  operand bundle handshake (in_ready high only in IDLE)
//   in_sign, in_ex       result sign, common (larger) exponent
//   in_sg1, in_sg2       aligned significands (smaller one complemented if signs differ)
//   in_ov_yn             1 = same-sign operands, carry-out is meaningful
//   out_valid/out_ready  result handshake; out_result held until accepted
//   out_result           packed {sign, exp, frac}
module fa_norm_pack #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned SIG_W = 24
) (
   input  logic                     CLK,
   input  logic                     RESETn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [EXP_W-1:0]         in_ex,
   input  logic [SIG_W-1:0]         in_sg1,
   input  logic [SIG_W-1:0]         in_sg2,
   input  logic                     in_ov_yn,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+SIG_W-1:0]   out_result
);

   localparam int unsigned FRAC_W = SIG_W - 1;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

   state_t              state;
   logic                sign_r;
   logic [EXP_W-1:0]    ex_r;
   logic [SIG_W-1:0]    sg1_r;
   logic [SIG_W-1:0]    sg2_r;
   logic                ov_r;
   // In NORM the leading bit is known to be 0, so only the lower bits are kept.
   logic [FRAC_W-1:0]   sig_r;

   logic [SIG_W:0]      sum_c;
   logic [EXP_W-1:0]    ex_inc_c;
   logic [EXP_W-1:0]    ex_dec_c;
   logic [SIG_W-1:0]    sig_shl_c;

   // Datapath helpers driven from registered state only.
   always_comb begin
      sum_c     = {1'b0, sg1_r} + {1'b0, sg2_r};
      ex_inc_c  = ex_r + EXP_W'(1);
      ex_dec_c  = ex_r - EXP_W'(1);
      sig_shl_c = {sig_r, 1'b0};
   end

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         sign_r     <= 1'b0;
         ex_r       <= '0;
         sg1_r      <= '0;
         sg2_r      <= '0;
         ov_r       <= 1'b0;
         sig_r      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_r   <= in_sign;
                  ex_r     <= in_ex;
                  sg1_r    <= in_sg1;
                  sg2_r    <= in_sg2;
                  ov_r     <= in_ov_yn;
                  in_ready <= 1'b0;
                  state    <= ADD;
               end
            end
            ADD: begin
               if (ov_r && sum_c[SIG_W]) begin
                  // Carry-out: drop the LSB and bump the exponent; may saturate to inf.
                  ex_r      <= ex_inc_c;
                  out_valid <= 1'b1;
                  state     <= DONE;
                  if (ex_inc_c == EXP_MAX)
                     out_result <= {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
                  else
                     out_result <= {sign_r, ex_inc_c, sum_c[SIG_W-1:1]};
               end else if (sum_c[SIG_W-1:0] == '0) begin
                  // Exact cancellation always yields +0.
                  out_result <= '0;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else if (sum_c[SIG_W-1]) begin
                  out_result <= {sign_r, ex_r, sum_c[SIG_W-2:0]};
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else begin
                  sig_r <= sum_c[SIG_W-2:0];
                  state <= NORM;
               end
            end
            NORM: begin
               if (ex_r <= EXP_ONE) begin
                  // Exponent exhausted: flush to zero instead of producing a denormal.
                  out_result <= '0;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else begin
                  sig_r <= sig_shl_c[FRAC_W-1:0];
                  ex_r  <= ex_dec_c;
                  if (sig_shl_c[SIG_W-1]) begin
                     out_result <= {sign_r, ex_dec_c, sig_shl_c[SIG_W-2:0]};
                     out_valid  <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fa_norm_pack.sv
// tb_fa_norm_pack: directed vectors with hand-computed results and latencies
// for fa_norm_pack, plus backpressure and mid-operation reset.
module tb_fa_norm_pack;

   logic        CLK;
   logic        RESETn;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_ex;
   logic [23:0] in_sg1;
   logic [23:0] in_sg2;
   logic        in_ov_yn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;

   int checks;
   int errors;

   fa_norm_pack dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_ex      (in_ex),
      .in_sg1     (in_sg1),
      .in_sg2     (in_sg2),
      .in_ov_yn   (in_ov_yn),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch one bundle, measure edges from E to out_valid, check result, then accept it.
   task automatic run_op(input string tag, input logic sign, input logic [7:0] ex,
                         input logic [23:0] sg1, input logic [23:0] sg2, input logic ov,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      lat = 0;
      in_sign  = sign;
      in_ex    = ex;
      in_sg1   = sg1;
      in_sg2   = sg2;
      in_ov_yn = ov;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      for (int n = 1; n <= 40; n++) begin
         @(posedge CLK);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, out_result, exp_res);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      RESETn    = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_ex     = 8'h00;
      in_sg1    = 24'h0;
      in_sg2    = 24'h0;
      in_ov_yn  = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'h0);
      @(negedge CLK);
      RESETn = 1'b1;
      @(posedge CLK);
      #1;

      run_op("one_plus_one",  1'b0, 8'h7F, 24'h800000, 24'h800000, 1'b1, 32'h4000_0000, 1);
      run_op("onep5_minus_1", 1'b0, 8'h7F, 24'h800000, 24'hC00000, 1'b0, 32'h3F00_0000, 2);
      run_op("one_minus_one", 1'b1, 8'h7F, 24'h800000, 24'h800000, 1'b0, 32'h0000_0000, 1);
      run_op("overflow_inf",  1'b1, 8'hFE, 24'h800000, 24'h800000, 1'b1, 32'hFF80_0000, 1);
      run_op("underflow",     1'b0, 8'h01, 24'h800001, 24'h800000, 1'b0, 32'h0000_0000, 2);
      run_op("same_no_carry", 1'b0, 8'h7F, 24'h800000, 24'h000001, 1'b1, 32'h3F80_0001, 1);
      run_op("norm15_neg",    1'b1, 8'h90, 24'h000000, 24'h000100, 1'b0, 32'hC080_0000, 16);
      run_op("norm_to_ex1",   1'b0, 8'h02, 24'h000000, 24'h400000, 1'b0, 32'h0080_0000, 2);
      run_op("flush_late",    1'b0, 8'h03, 24'h000000, 24'h000010, 1'b0, 32'h0000_0000, 4);

      // Backpressure: result must hold while out_ready stays low.
      in_sign  = 1'b0;
      in_ex    = 8'h7F;
      in_sg1   = 24'h800000;
      in_sg2   = 24'h800000;
      in_ov_yn = 1'b1;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", out_result, 32'h4000_0000);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge CLK);
         #1;
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;

      // Reset during NORM aborts the op and clears the held result.
      in_sign  = 1'b0;
      in_ex    = 8'h7F;
      in_sg1   = 24'h000000;
      in_sg2   = 24'h000001;
      in_ov_yn = 1'b0;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("pre_rst_busy", {30'd0, in_ready, out_valid}, 32'b00);
      RESETn = 1'b0;
      #2;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_result", out_result, 32'h0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (30) @(posedge CLK);
      #1;
      check("post_rst_no_result", {30'd0, in_ready, out_valid}, 32'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
